lifo_stack_core: RTL and testbench
==================================

LIFO_STACK_CORE -- requirements
Module: lifo_stack_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of stored words.
REQ-002 SHALL have parameter POINTER_WIDTH, default 4, log2 of stack depth (DEPTH = 2**POINTER_WIDTH = 16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr, input, 1, push request.
REQ-006 SHALL have port rd, input, 1, pop request.
REQ-007 SHALL have port clr, input, 1, synchronous flush of the stack.
REQ-008 SHALL have port data_in, input, DATA_WIDTH, word to push.
REQ-009 SHALL have port data_out, output, DATA_WIDTH, last popped word, registered.
REQ-010 SHALL have port data_valid, output, 1, one-cycle pulse marking a new data_out.
REQ-011 SHALL have port lifo_empty, output, 1, high when occupancy is 0; feeds status_signal_LIFO.
REQ-012 SHALL have port lifo_full, output, 1, high when occupancy equals DEPTH; feeds status_signal_LIFO.
REQ-013 SHALL have port pointer, output, POINTER_WIDTH+1, current occupancy 0..DEPTH; zero-extended to 10 bits at the status_signal_LIFO input.

Function
REQ-014 SHALL accept a push when wr=1 and lifo_full=0: mem[pointer] <= data_in, pointer <= pointer+1.
REQ-015 SHALL accept a pop when rd=1 and lifo_empty=0: data_out <= mem[pointer-1], pointer <= pointer-1, data_valid=1 next cycle.
REQ-016 SHALL give pop latency of exactly 1 clock: data_out and data_valid update on the edge that samples rd.
REQ-017 SHALL, on wr=1 and rd=1 with lifo_empty=0 (including full), perform a replace: data_out <= top word, top overwritten with data_in, pointer unchanged, data_valid=1.
REQ-018 SHALL, on wr=1 and rd=1 with lifo_empty=1, perform a push only; data_valid=0.
REQ-019 SHALL ignore wr while full (no write, pointer held); ignore rd while empty (data_out held, data_valid=0); error flagging is left to status_signal_LIFO.
REQ-020 SHALL give clr priority over wr and rd: pointer <= 0, data_valid <= 0, data_out held; memory contents not cleared.
REQ-021 SHALL derive lifo_empty and lifo_full from the registered pointer, so they change on the same edge as pointer, with no combinational path from wr/rd.
REQ-022 SHALL never let pointer exceed DEPTH or wrap below 0; the write address is the low POINTER_WIDTH bits of pointer.
REQ-023 SHALL hold data_valid=0 on any cycle without an accepted pop or replace.

Reset
REQ-024 SHALL, on rst_n=0 (asynchronous assert, synchronous release), force pointer=0, lifo_empty=1, lifo_full=0, data_out=0, data_valid=0.
REQ-025 SHALL abort any in-flight operation on reset mid-operation; the first request after release acts on an empty stack.
REQ-026 SHALL not reset memory contents.

Structure
REQ-027 SHALL take DATA_WIDTH, POINTER_WIDTH, DEPTH and TH_LEVEL (DEPTH/2) from shared package lifo_pkg, which status_signal_LIFO uses too.
REQ-028 SHALL place storage in one sub-module lifo_ram: DEPTH x DATA_WIDTH, synchronous write, synchronous read, single clock.
REQ-029 SHALL keep pointer/flag control and the data_valid register in lifo_stack_core.

Verification
REQ-030 Reset: assert rst_n=0 mid-push sequence -> pointer=0, lifo_empty=1, lifo_full=0, data_valid=0 immediately, before the next clk edge.
REQ-031 Fill/drain: push 0x0001..0x0010 (16 words) -> lifo_full=1, pointer=16; then pop 16 times -> data_out 0x0010 down to 0x0001, one per cycle, each with data_valid; end lifo_empty=1.
REQ-032 Overflow: when full, push 0xBEEF -> pointer stays 16; next pop returns 0x0010, not 0xBEEF.
REQ-033 Underflow: when empty, rd=1 for 3 cycles -> data_valid=0, pointer=0, data_out unchanged.
REQ-034 Simultaneous: with pointer=3, top=0x0003, drive wr=1, rd=1, data_in=0xAAAA -> data_out=0x0003, pointer=3; next pop returns 0xAAAA.
REQ-035 Flush: with pointer=5, drive clr=1, wr=1 -> pointer=0, lifo_empty=1, no write; paired with status_signal_LIFO, lifo_ov and lifo_ud stay low.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared LIFO constants and the per-cycle operation decode type.
// status_signal_LIFO imports this package too, so it keeps the same depth and threshold.
package lifo_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int POINTER_WIDTH = 4;
  localparam int DEPTH         = 2 ** POINTER_WIDTH;
  localparam int TH_LEVEL      = DEPTH / 2;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_CLEAR
  } op_t;

endpackage

// File: rtl/lifo_stack_core_if.sv
// Request/response bundle between a stack user (master) and lifo_stack_core (slave).
interface lifo_stack_core_if
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH    = lifo_pkg::DATA_WIDTH,
  parameter int POINTER_WIDTH = lifo_pkg::POINTER_WIDTH
);

  logic                     wr;
  logic                     rd;
  logic                     clr;
  logic [DATA_WIDTH-1:0]    data_in;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_valid;
  logic                     lifo_empty;
  logic                     lifo_full;
  logic [POINTER_WIDTH:0]   pointer;

  modport master (
    output wr, rd, clr, data_in,
    input  data_out, data_valid, lifo_empty, lifo_full, pointer
  );

  modport slave (
    input  wr, rd, clr, data_in,
    output data_out, data_valid, lifo_empty, lifo_full, pointer
  );

endinterface

// File: rtl/lifo_ram.sv
// Stack storage: synchronous write, registered synchronous read, one clock.
// Only the read register is reset; the array keeps its contents.
module lifo_ram #(
  parameter int DATA_WIDTH    = 16,
  parameter int POINTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [POINTER_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [POINTER_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam int DEPTH = 2 ** POINTER_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read samples the pre-write value, so a same-address replace returns the old top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lifo_stack_core.sv
// LIFO stack controller: occupancy pointer, empty/full flags and pop-valid pulse.
// data_out is the registered read port of lifo_ram.
module lifo_stack_core
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH    = lifo_pkg::DATA_WIDTH,
  parameter int POINTER_WIDTH = lifo_pkg::POINTER_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  lifo_stack_core_if.slave   bus
);

  localparam logic [POINTER_WIDTH:0] PTR_ONE = {{POINTER_WIDTH{1'b0}}, 1'b1};
  localparam logic [POINTER_WIDTH:0] PTR_MAX = {1'b1, {POINTER_WIDTH{1'b0}}};

  op_t                      op;
  logic [POINTER_WIDTH:0]   ptr_q;
  logic [POINTER_WIDTH:0]   ptr_d;
  logic [POINTER_WIDTH:0]   ptr_dec;
  logic                     dv_q;
  logic                     dv_d;
  logic                     empty;
  logic                     full;
  logic                     ram_we;
  logic                     ram_re;
  logic [POINTER_WIDTH-1:0] top_addr;
  logic [POINTER_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    rdata;

  // Flags come only from the registered pointer, never from wr/rd.
  assign empty    = (ptr_q == '0);
  assign full     = (ptr_q == PTR_MAX);
  assign ptr_dec  = ptr_q - PTR_ONE;
  assign top_addr = ptr_dec[POINTER_WIDTH-1:0];

  always_comb begin
    op = OP_IDLE;
    if (bus.clr) begin
      op = OP_CLEAR;
    end else if (bus.wr && bus.rd && !empty) begin
      op = OP_REPLACE;
    end else if (bus.wr && !full) begin
      op = OP_PUSH;
    end else if (bus.rd && !empty) begin
      op = OP_POP;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    dv_d  = 1'b0;
    case (op)
      OP_CLEAR:   ptr_d = '0;
      OP_PUSH:    ptr_d = ptr_q + PTR_ONE;
      OP_POP: begin
        ptr_d = ptr_dec;
        dv_d  = 1'b1;
      end
      OP_REPLACE: dv_d = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      dv_q  <= dv_d;
    end
  end

  assign ram_we = (op == OP_PUSH) || (op == OP_REPLACE);
  assign ram_re = (op == OP_POP)  || (op == OP_REPLACE);
  assign waddr  = (op == OP_REPLACE) ? top_addr : ptr_q[POINTER_WIDTH-1:0];

  lifo_ram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .POINTER_WIDTH (POINTER_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (bus.data_in),
    .re    (ram_re),
    .raddr (top_addr),
    .rdata (rdata)
  );

  assign bus.data_out   = rdata;
  assign bus.data_valid = dv_q;
  assign bus.pointer    = ptr_q;
  assign bus.lifo_empty = empty;
  assign bus.lifo_full  = full;

endmodule

// File: tb/tb_lifo_stack_core.sv
// Directed bench for lifo_stack_core: a vector table plus fill/drain, overflow,
// underflow, replace, flush and mid-operation reset sequences.
module tb_lifo_stack_core;

  logic clk;
  logic rst_n;

  lifo_stack_core_if bus ();

  lifo_stack_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        clr;
    logic [15:0] din;
    logic [4:0]  e_ptr;
    logic [15:0] e_dout;
    logic        e_dv;
    logic        e_empty;
    logic        e_full;
  } vec_t;

  vec_t vecs [12];
  int   n_pass;
  int   n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic [15:0] d);
    bus.wr = w; bus.rd = r; bus.clr = c; bus.data_in = d;
  endtask

  // Apply inputs, clock once, release inputs, sample 1 ns after the edge.
  task automatic cycle(input logic w, input logic r, input logic c, input logic [15:0] d);
    drive(w, r, c, d);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic chk_state(input string name, input logic [4:0] p, input logic [15:0] dout,
                           input logic dv, input logic em, input logic fu);
    chk({name, ".state"},
        {bus.pointer, bus.data_out, bus.data_valid, bus.lifo_empty, bus.lifo_full},
        {p, dout, dv, em, fu});
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);

    //          wr    rd    clr   din       ptr    dout      dv    empty full
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0011, 5'd1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0022, 5'd2, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd1, 16'h0022, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 16'h0022, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0033, 5'd1, 16'h0011, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 16'h0033, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 16'h0033, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0044, 5'd1, 16'h0033, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0055, 5'd2, 16'h0033, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'h0077, 5'd0, 16'h0033, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0066, 5'd1, 16'h0033, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 16'h0066, 1'b1, 1'b1, 1'b0};

    do_reset();
    chk_state("reset", 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      chk_state($sformatf("vec%0d", i), vecs[i].e_ptr, vecs[i].e_dout,
                vecs[i].e_dv, vecs[i].e_empty, vecs[i].e_full);
    end

    // Fill, overflow, drain.
    do_reset();
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i));
    chk_state("fill", 5'd16, 16'h0000, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 16'hBEEF);
    chk_state("overflow", 5'd16, 16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 16; i >= 1; i--) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      chk_state($sformatf("drain%0d", i), 5'(i - 1), 16'(i), 1'b1, (i == 1), 1'b0);
    end

    // Underflow: three pops on empty.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      chk_state($sformatf("underflow%0d", i), 5'd0, 16'h0001, 1'b0, 1'b1, 1'b0);
    end

    // Replace with pointer=3, top=0x0003.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i));
    cycle(1'b1, 1'b1, 1'b0, 16'hAAAA);
    chk_state("replace", 5'd3, 16'h0003, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_state("replace_pop", 5'd2, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_state("below_replace", 5'd1, 16'h0002, 1'b1, 1'b0, 1'b0);

    // Replace while full: pointer stays 16.
    do_reset();
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i + 16'h0100));
    cycle(1'b1, 1'b1, 1'b0, 16'h5A5A);
    chk_state("replace_full", 5'd16, 16'h0110, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_state("replace_full_pop", 5'd15, 16'h5A5A, 1'b1, 1'b0, 1'b0);

    // Flush with pointer=5 and a concurrent push.
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i + 16'h0200));
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_state("pre_flush", 5'd4, 16'h0205, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 16'hDEAD);
    chk_state("flush", 5'd0, 16'h0205, 1'b0, 1'b1, 1'b0);

    // Reset asserted mid-sequence must act before the next edge.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i + 16'h0300));
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_state("pre_reset", 5'd3, 16'h0304, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0999);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_state("async_reset", 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_state("reset_held", 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_state("pop_after_reset", 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0C0C);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_state("push_pop_after_reset", 5'd0, 16'h0C0C, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
